// File: rtl/mmio_hub.sv
// mmio_hub: memory-mapped I/O hub for the OTTER_MCU IOBUS.
// Slot k sits at BASE_AD + k*STRIDE. Slots are laid out as input ports,
// then output ports, then IRQ_PEND, IRQ_MASK and IRQ_ID.
// An edge-triggered interrupt controller drives INTR.
module mmio_hub #(
    parameter logic [31:0] BASE_AD = 32'h11000000,
    parameter logic [31:0] STRIDE  = 32'h00040000,
    parameter int          N_IN    = 4,
    parameter int          N_OUT   = 4,
    parameter int          OUT_W   = 32,
    parameter int          N_IRQ   = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [31:0]              IOBUS_ADDR,
    input  logic [31:0]              IOBUS_OUT,
    input  logic                     IOBUS_WR,
    output logic [31:0]              IOBUS_IN,
    input  logic [32*N_IN-1:0]       IN_DATA,
    output logic [OUT_W*N_OUT-1:0]   OUT_DATA,
    output logic [N_OUT-1:0]         OUT_STB,
    input  logic [N_IRQ-1:0]         IRQ_SRC,
    output logic                     INTR
);

    function automatic logic [31:0] slot_ad(input int k);
        return BASE_AD + STRIDE * 32'(k);
    endfunction

    localparam logic [31:0] A_PEND = BASE_AD + STRIDE * 32'(N_IN + N_OUT);
    localparam logic [31:0] A_MASK = BASE_AD + STRIDE * 32'(N_IN + N_OUT + 1);
    localparam logic [31:0] A_ID   = BASE_AD + STRIDE * 32'(N_IN + N_OUT + 2);

    logic [N_OUT-1:0][OUT_W-1:0] r_out;
    logic [N_OUT-1:0]            r_stb;
    logic [N_IRQ-1:0]            r_sync1;
    logic [N_IRQ-1:0]            r_sync2;
    logic [N_IRQ-1:0]            r_dly;
    logic [N_IRQ-1:0]            r_pend;
    logic [N_IRQ-1:0]            r_mask;

    logic [N_OUT-1:0]            w_out_hit;
    logic                        w_wr_pend;
    logic                        w_wr_mask;
    logic [N_IRQ-1:0]            w_edge;
    logic [N_IRQ-1:0]            w_clr;
    logic [N_IRQ-1:0]            w_act;
    logic [4:0]                  w_idx;
    logic [31:0]                 w_rd;
    logic [31:0]                 w_ext;

    assign w_wr_pend = IOBUS_WR && (IOBUS_ADDR == A_PEND);
    assign w_wr_mask = IOBUS_WR && (IOBUS_ADDR == A_MASK);
    assign w_edge    = r_sync2 & ~r_dly;
    assign w_clr     = w_wr_pend ? IOBUS_OUT[N_IRQ-1:0] : '0;
    assign w_act     = r_pend & r_mask;
    assign INTR      = |w_act;
    assign OUT_DATA  = r_out;
    assign OUT_STB   = r_stb;
    assign IOBUS_IN  = w_rd;

    // Exact-match decode of the output port slots.
    always_comb begin
        w_out_hit = '0;
        for (int j = 0; j < N_OUT; j++) begin
            w_out_hit[j] = (IOBUS_ADDR == slot_ad(N_IN + j));
        end
    end

    // Lowest-numbered active (pending and unmasked) source.
    always_comb begin
        w_idx = 5'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_act[i]) w_idx = 5'(i);
        end
    end

    // Combinational read mux; unmapped addresses read zero.
    always_comb begin
        w_rd  = 32'h0;
        w_ext = 32'h0;
        for (int i = 0; i < N_IN; i++) begin
            if (IOBUS_ADDR == slot_ad(i)) w_rd = IN_DATA[32*i +: 32];
        end
        for (int j = 0; j < N_OUT; j++) begin
            if (w_out_hit[j]) begin
                w_ext              = 32'h0;
                w_ext[OUT_W-1:0]   = r_out[j];
                w_rd               = w_ext;
            end
        end
        if (IOBUS_ADDR == A_PEND) w_rd[N_IRQ-1:0] = r_pend;
        if (IOBUS_ADDR == A_MASK) w_rd[N_IRQ-1:0] = r_mask;
        if (IOBUS_ADDR == A_ID) begin
            w_rd[31]  = INTR;
            w_rd[4:0] = w_idx;
        end
    end

    // Output port registers and their one-cycle write strobes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_out <= '0;
            r_stb <= '0;
        end else begin
            r_stb <= IOBUS_WR ? w_out_hit : '0;
            for (int j = 0; j < N_OUT; j++) begin
                if (IOBUS_WR && w_out_hit[j]) r_out[j] <= IOBUS_OUT[OUT_W-1:0];
            end
        end
    end

    // Two-flop synchroniser plus delay flop for edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_dly   <= '0;
        end else begin
            r_sync1 <= IRQ_SRC;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
        end
    end

    // Pending (edge sets, write-1 clears, set wins) and mask registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pend <= '0;
            r_mask <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_edge;
            if (w_wr_mask) r_mask <= IOBUS_OUT[N_IRQ-1:0];
        end
    end

endmodule

// File: doc/mmio_hub.md
# mmio_hub

Parametrised memory-mapped I/O hub between the OTTER_MCU IOBUS and board peripherals. Generalises fixed per-address peripheral decode into N_IN input ports, N_OUT registered output ports with write strobes, and an N_IRQ-source interrupt controller. The controller has synchronisers, edge detection, pending/mask registers and a priority ID, and drives the MCU interrupt input.

## Interface
- BASE_AD, 32'h11000000, address of slot 0
- STRIDE, 32'h00040000, address distance between slots
- N_IN, 4, input ports (1..8)
- N_OUT, 4, output ports (1..8)
- OUT_W, 32, output port width (1..32)
- N_IRQ, 4, interrupt sources (1..31)

Ports:
- CLK  in  1  system clock; all state on rising edge
- RST  in  1  reset; asynchronous, active-high
- IOBUS_ADDR  in  32  CPU I/O address
- IOBUS_OUT  in  32  CPU write data
- IOBUS_WR  in  1  CPU write enable
- IOBUS_IN  out  32  read data to CPU
- IN_DATA  in  32*N_IN  input port values, port i at bits [32i+31:32i]
- OUT_DATA  out  OUT_W*N_OUT  registered output port values
- OUT_STB  out  N_OUT  one-cycle strobe per output port write
- IRQ_SRC  in  N_IRQ  interrupt sources; may be asynchronous to CLK
- INTR  out  1  interrupt request to MCU

## Operation
- Slot k address = BASE_AD + k*STRIDE.
- Slot map:
  - Slots 0..N_IN-1: input ports, read-only.
  - Slots N_IN..N_IN+N_OUT-1: output ports, read/write.
  - Slot P = N_IN+N_OUT: IRQ_PEND, read, write-1-to-clear.
  - Slot P+1: IRQ_MASK, read/write.
  - Slot P+2: IRQ_ID, read-only.
- Decode is exact 32-bit match. Any other address reads 0; writes to it are ignored.
- Writes to read-only slots are ignored.
- Output write: OUT_DATA[j] <= IOBUS_OUT[OUT_W-1:0]; OUT_STB[j] pulses for exactly one cycle. Reading back returns the register zero-extended to 32 bits.
- IRQ path per source:
  - 2-flop synchroniser, then a delay flop.
  - Rising edge (sync=1, delayed=0) sets pend[i].
  - Level-high sources produce one event only.
- IRQ_PEND write: bits where IOBUS_OUT[i]=1 clear pend[i]. If a new edge arrives in the same cycle as the clear, set wins.
- IRQ_MASK: mask[N_IRQ-1:0] <= IOBUS_OUT[N_IRQ-1:0]. Masked sources still latch pending.
- INTR = |(pend & mask), combinational from registers.
- IRQ_ID read:
  - bit31 = |(pend & mask).
  - bits[4:0] = lowest index i with pend[i]&mask[i], or 0 if none.
  - All other bits 0.
  - Reading does not clear pending.
- Read path: IOBUS_IN is combinational from IOBUS_ADDR and current register state.

## Timing
- Reset values: OUT_DATA=0, OUT_STB=0, pend=0, mask=0, sync/delay flops=0, INTR=0. IOBUS_IN follows the current address.
- Write latency: OUT_DATA and OUT_STB change at the CLK edge sampling IOBUS_WR=1. OUT_STB drops at the next edge unless written again.
- Back-to-back writes to the same port: OUT_STB stays high and OUT_DATA updates every cycle.
- IRQ latency: IRQ_SRC rises just before edge 0. pend is set after edge 2, so INTR is high in cycle 3 if masked in.
- Mask write takes effect on INTR in the cycle after the write edge. Clear on IRQ_PEND likewise.
- RST asserted mid-operation clears all state immediately, including pending events and in-flight synchroniser bits. A source held high through reset release produces one event after release.

## Test plan
- Reset: pulse RST with IRQ_SRC=0 -> all OUT_DATA=0, OUT_STB=0, INTR=0; read 0x11280000 -> 0x00000000.
- Output port: write 0xDEADBEEF to 0x11140000 -> next cycle OUT_DATA[1]=0xDEADBEEF, OUT_STB=4'b0010 for one cycle; read 0x11140000 -> 0xDEADBEEF.
- Input and unmapped: IN_DATA[2]=0x0000A5A5 -> read 0x11080000 returns 0x0000A5A5. Read 0x11300000 -> 0. Write to 0x11000000 -> no OUT_STB, no state change.
- Interrupt flow:
  - Write MASK 0x11240000=0x6.
  - Raise IRQ_SRC[2] and IRQ_SRC[0] -> after 3 cycles pend=0x5, INTR=1, ID read=0x80000002.
  - Write 0x4 to 0x11200000 -> pend=0x1, INTR=0, ID=0x00000000.
- Set-wins: IRQ_SRC[1] edge reaches pend in the same cycle as a W1C of bit 1 -> pend[1]=1.
- Mid-reset: raise IRQ_SRC[3] and hold; assert RST while pend[3]=1 -> pend=0. After release, with mask=0x8 -> pend[3]=1 again after 3 cycles, INTR=1.
